// File: rtl/scalar_flag_unit.sv
// scalar_flag_unit: architectural NZVC flag register with in-flight flag-writer
// tracking and a condition-code evaluator behind a valid/ready query handshake.
module scalar_flag_unit #(
  parameter int MAX_PENDING = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_setflags,
  input  logic       flush,
  input  logic       wb_valid,
  input  logic       wb_setflags,
  input  logic [3:0] wb_flags,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       res_valid,
  output logic       res_taken,
  input  logic       res_ready,
  output logic [3:0] flags,
  output logic       pending_full,
  output logic       err
);

  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] pending_r;
  logic [3:0]    flags_r;
  logic [3:0]    code_r;
  logic          res_valid_r;
  logic          res_taken_r;
  logic          err_r;

  logic full_s;
  logic flag_wr_s;
  logic inc_s;
  logic dec_s;
  logic resolve_s;
  logic err_set_s;

  // Evaluate a 4-bit condition code against {N,Z,V,C}.
  function automatic logic eval_cond(input logic [3:0] f, input logic [3:0] code);
    logic n, z, v, c, r;
    {n, z, v, c} = f;
    case (code)
      4'd0:    r = z;
      4'd1:    r = ~z;
      4'd2:    r = c;
      4'd3:    r = ~c;
      4'd4:    r = n;
      4'd5:    r = ~n;
      4'd6:    r = v;
      4'd7:    r = ~v;
      4'd8:    r = c & ~z;
      4'd9:    r = ~c | z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = ~z & (n == v);
      4'd13:   r = z | (n != v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign full_s    = (pending_r == PEND_MAX);
  assign flag_wr_s = wb_valid & wb_setflags;
  assign inc_s     = issue_setflags & ~full_s;
  assign dec_s     = flag_wr_s & (pending_r != {CW{1'b0}});
  // AL/NV never depend on flags, so they need not wait for writers to drain.
  assign resolve_s = (pending_r == {CW{1'b0}}) | (code_r == 4'd14) | (code_r == 4'd15);
  assign err_set_s = (issue_setflags & full_s) | (flag_wr_s & (pending_r == {CW{1'b0}}));

  // In-flight flag-writer count; flush wins but keeps a same-cycle issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {CW{1'b0}};
    end else if (flush) begin
      pending_r <= inc_s ? CW'(1) : {CW{1'b0}};
    end else if (inc_s & ~dec_s) begin
      pending_r <= pending_r + CW'(1);
    end else if (dec_s & ~inc_s) begin
      pending_r <= pending_r - CW'(1);
    end else begin
      pending_r <= pending_r;
    end
  end

  // Architectural flags and the sticky protocol-error bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_r <= 4'b0000;
      err_r   <= 1'b0;
    end else begin
      flags_r <= flag_wr_s ? wb_flags : flags_r;
      err_r   <= err_r | err_set_s;
    end
  end

  // Query FSM: accept, wait for outstanding writers, hold result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      code_r      <= 4'd0;
      res_valid_r <= 1'b0;
      res_taken_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cond_valid) begin
            code_r  <= cond_code;
            state_r <= WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (resolve_s) begin
            res_taken_r <= eval_cond(flags_r, code_r);
            res_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign cond_ready   = (state_r == IDLE);
  assign res_valid    = res_valid_r;
  assign res_taken    = res_taken_r;
  assign flags        = flags_r;
  assign pending_full = full_s;
  assign err          = err_r;

endmodule

// File: doc/scalar_flag_unit.md
# scalar_flag_unit

Architectural NZVC flag register and condition evaluator for the scalar datapath: the consumer side of the scalar ALU's result/flags interface. Captures the 4-bit flags `{N,Z,V,C}` produced on writeback. Tracks flag-setting instructions still in flight. Answers condition-code queries from the sequencer over a valid/ready handshake, waiting until no flag writer is outstanding.

## Interface
- `MAX_PENDING`, default 3: maximum in-flight flag-setting instructions. The counter is `$clog2(MAX_PENDING+1)` bits wide; `MAX_PENDING` must be ≥ 1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `issue_setflags` in 1: a flag-setting scalar instruction issues this cycle.
- `flush` in 1: squash all in-flight instructions; clears the pending count.
- `wb_valid` in 1: an ALU writeback is present this cycle.
- `wb_setflags` in 1: this writeback updates the flags.
- `wb_flags` in 4: `{N,Z,V,C}` from the ALU.
- `cond_valid` in 1: condition query valid.
- `cond_code` in 4: condition to evaluate.
- `cond_ready` out 1: query can be accepted.
- `res_valid` out 1: result valid.
- `res_taken` out 1: condition evaluated true.
- `res_ready` in 1: consumer accepts the result.
- `flags` out 4: architectural `{N,Z,V,C}` register.
- `pending_full` out 1: pending count == `MAX_PENDING`; the issue stage must stall.
- `err` out 1: sticky protocol error.

## Operation
- **Flag write:** when `wb_valid & wb_setflags`, `flags <= wb_flags`.
  - If `wb_valid` is 1 and `wb_setflags` is 0, the writeback is ignored.
- **Pending counter:**
  - `inc = issue_setflags & !pending_full`.
  - `dec = wb_valid & wb_setflags & (pending != 0)`.
  - `inc` and `dec` together: count unchanged.
  - `flush` has priority: it sets the count to 0, except that a same-cycle `inc` makes the count 1. `flush` does not touch `flags` or the FSM.
- **Error conditions** (each sets `err`; `err` is cleared only by `rst`):
  - `issue_setflags` while full: the issue is dropped.
  - Flag writeback while the pending count is 0: the flags are still written and the count stays at 0.
- **Condition codes** (on the registered `flags`):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- **FSM states:** IDLE, WAIT, RESP.
  - **IDLE:** `cond_ready=1`. On `cond_valid`, latch `cond_code` and go to WAIT.
  - **WAIT:** `cond_ready=0`. If the registered pending count is 0, or the code is AL/NV:
    - `res_taken <= eval(flags, code)`, `res_valid <= 1`, go to RESP.
    - Otherwise stay in WAIT.
  - **RESP:** `res_valid` and `res_taken` are held stable until `res_ready`. On `res_valid & res_ready`, clear `res_valid` and go to IDLE.
- A `flush` during WAIT clears the pending count. The next WAIT cycle then resolves using the current `flags`.

## Timing
- Reset values: state IDLE, `flags=0000`, pending 0, `res_valid=0`, `res_taken=0`, `err=0`, `pending_full=0`, `cond_ready=1`.
- Minimum query latency: query accepted at edge E0 (WAIT is entered); `res_valid` is high after E1 when pending is 0. The response is visible the cycle after acceptance.
- A flag writeback at edge Ek that brings pending to 0 is visible to evaluation in the following WAIT cycle. The result therefore reflects the last writer's flags, with `res_valid` asserted after edge Ek+1.
- `cond_ready` depends only on state (no combinational path from `cond_valid`). One query is outstanding at a time, so maximum throughput is one query per 3 cycles.
- `pending_full` and `flags` are registered-state outputs.
- `rst` mid-WAIT or mid-RESP aborts to IDLE immediately; the result is lost.

## Test plan
- Reset, then query EQ with no pending: expect `res_valid` one cycle after acceptance, `res_taken=0`, `flags=0000`.
- Issue 2 setflags, query LT (WAIT). Write back `flags=1000`, then `0000`: expect the result one cycle after the second writeback with `res_taken=0`; `res_valid` is never asserted before that.
- Issue 3 setflags (`MAX_PENDING=3`) → `pending_full=1`. A fourth issue → dropped, `err=1`, count stays 3.
- Same-cycle issue and writeback with pending=1 → count stays 1 and `flags` are updated.
- Query AL while pending=2 → `res_taken=1` one cycle after acceptance. Hold `res_ready=0` for 4 cycles → `res_valid`/`res_taken` stable and `cond_ready=0`.
- Query GT in WAIT with pending=1, then assert `flush` → resolves on the current `flags`. Separately, assert `rst` during RESP → all outputs return to their reset values.
